// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory request generation, wait/timeout FSM,
// load extraction and the MEM/WB register.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_RegWrite,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_MemToReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_rd,
    output logic        wb_RegWrite,
    output logic        wb_MemToReg
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          legal, access, illegal, timeout_now;
    logic [1:0]    off;

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  o);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{o, 3'b000} +: 8];
        h = o[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            3'b010:  return rdata;
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            3'b000:  return 4'b0001 << o;
            3'b001:  return o[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3)
            3'b000:  return {4{rs2[7:0]}};
            3'b001:  return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    assign off = ex_alu_result[1:0];

    always_comb begin
        legal = 1'b0;
        if (ex_MemRead) begin
            case (ex_funct3)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = ~off[0];
                3'b010:         legal = (off == 2'b00);
                default:        legal = 1'b0;
            endcase
        end else if (ex_MemWrite) begin
            case (ex_funct3)
                3'b000:  legal = 1'b1;
                3'b001:  legal = ~off[0];
                3'b010:  legal = (off == 2'b00);
                default: legal = 1'b0;
            endcase
        end
    end

    assign access      = (ex_MemRead | ex_MemWrite) & legal;
    assign illegal     = (ex_MemRead | ex_MemWrite) & ~legal;
    assign timeout_now = (state_q == WAIT) && (cnt_q == CW'(MAX_WAIT)) && !dmem_ready;

    assign dmem_addr  = {ex_alu_result[31:2], 2'b00};
    assign dmem_we    = ex_MemWrite;
    assign dmem_be    = store_be(ex_funct3, off);
    assign dmem_wdata = store_wdata(ex_funct3, ex_rs2_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is high, even mid-wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dmem_req  = 1'b0;
        mem_fault = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req  = access;
                mem_fault = illegal;
                if (access && !dmem_ready) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                dmem_req  = ~timeout_now;
                mem_fault = timeout_now;
                if (dmem_ready || timeout_now) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            dmem_req  = 1'b0;
            mem_fault = 1'b0;
        end
    end

    assign mem_stall = dmem_req & ~dmem_ready;

    // A non-stalled cycle with dmem_req high is a completing access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_rd         <= '0;
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
        end else if (mem_stall) begin
            wb_RegWrite <= 1'b0;
        end else begin
            wb_alu_result <= ex_alu_result;
            wb_mem_data   <= (dmem_req && ex_MemRead) ? load_extract(dmem_rdata, ex_funct3, off) : 32'b0;
            wb_rd         <= ex_rd;
            wb_RegWrite   <= ex_RegWrite & ~mem_fault;
            wb_MemToReg   <= ex_MemToReg;
        end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MAX_WAIT, default 15, maximum dmem wait cycles before a timeout fault.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 ex_alu_result  in  32  effective address or ALU result from the EX/MEM register.
REQ-005 ex_rs2_data  in  32  forwarded store data.
REQ-006 ex_rd  in  5; ex_funct3  in  3; ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg  in  1 each  EX/MEM control.
REQ-007 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (bits[1:0]=0); dmem_wdata  out  32; dmem_be  out  4  data-memory request.
REQ-008 dmem_ready  in  1; dmem_rdata  in  32  completion strobe, read data valid when dmem_ready=1.
REQ-009 mem_stall  out  1  upstream stages and EX/MEM hold when 1.
REQ-010 mem_fault  out  1  one-cycle pulse on misalignment, bad funct3 or timeout.
REQ-011 wb_alu_result, wb_mem_data  out  32; wb_rd  out  5; wb_RegWrite, wb_MemToReg  out  1  MEM/WB register.

Function
REQ-012 The FSM SHALL have states IDLE and WAIT, plus a wait counter of width clog2(MAX_WAIT+1).
REQ-013 An access is ex_MemRead|ex_MemWrite with legal alignment and funct3; dmem_req SHALL be asserted combinationally in IDLE for an access and held in WAIT.
REQ-014 Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0; loads funct3 011/110/111 and stores funct3 >010 are illegal.
REQ-015 dmem_addr = {ex_alu_result[31:2],2'b00}; dmem_we = ex_MemWrite.
REQ-016 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2.
REQ-017 mem_stall SHALL be combinational = (access active) & ~dmem_ready & ~timeout_now.
REQ-018 IDLE with dmem_ready=1 during an access SHALL complete in the same cycle (zero-wait); otherwise next state WAIT, counter=1.
REQ-019 WAIT: on dmem_ready -> IDLE, capture result; else counter increments; when counter==MAX_WAIT with no ready -> timeout_now, dmem_req deasserted, mem_fault=1, -> IDLE.
REQ-020 Load extraction from dmem_rdata by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-021 MEM/WB SHALL update each non-stalled cycle: wb_alu_result<=ex_alu_result, wb_mem_data<=extracted load (0 for non-loads), wb_rd<=ex_rd, wb_MemToReg<=ex_MemToReg, wb_RegWrite<=ex_RegWrite.
REQ-022 During stall cycles wb_RegWrite SHALL be registered 0 (bubble); other wb fields hold.
REQ-023 Illegal access or timeout: no dmem_req (illegal) / dropped req (timeout), mem_fault pulses in that cycle, wb_RegWrite<=0, no stall.
REQ-024 Non-memory instructions SHALL pass through with 1-cycle latency and no dmem_req.
REQ-025 dmem_ready while dmem_req=0 SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, counter 0 and all registered outputs to 0; combinational outputs (dmem_req, mem_stall, mem_fault) SHALL be 0 while reset=1.
REQ-027 Reset asserted in WAIT SHALL drop dmem_req immediately; no completion is recorded after reset release.

Verification
REQ-028 LW addr 0x100, ready same cycle, rdata 0xDEADBEEF -> no stall; next edge wb_mem_data=0xDEADBEEF, wb_RegWrite=1.
REQ-029 LB addr 0x103, rdata 0x80112233, ready after 3 cycles -> mem_stall=1 for 3 cycles with wb_RegWrite=0; then wb_mem_data=0xFFFFFF80.
REQ-030 SH addr 0x202, rs2=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, dmem_we=1.
REQ-031 LW addr 0x101 -> dmem_req=0, mem_fault one pulse, wb_RegWrite=0, no stall.
REQ-032 MAX_WAIT=4, LW with dmem_ready held 0 -> stall 4 cycles, mem_fault pulse, return to IDLE; separately reset asserted in WAIT -> dmem_req=0 and all wb outputs 0 immediately.
